gaussian_frame_arbiter: RTL and testbench
=========================================

Name: gaussian_frame_arbiter

Overview:
- Shares one GAUSSIAN filter instance between two octave streams (requester 0 and requester 1).
- Each requester has a source FIFO (from down-sample) and a destination FIFO (to up-sample).
- Grants the filter for one whole frame at a time, round-robin.
- Per granted frame: resets the filter pipeline, streams pixels through with clock-enable gating, then drains the pipeline with zero padding before re-arbitrating.

Parameters:
- IMG_W, 160, frame width in pixels.
- IMG_H, 120, frame height in pixels; PIX = IMG_W*IMG_H.
- LAT, 323, filter latency in enabled clocks (input step k appears at dout during step k+LAT). Must be >= 1, and PIX+LAT < 2^18.

Ports:
- clk  in  1  system clock.
- global_reset  in  1  synchronous, active-high reset.
- src0_data  in  8  requester 0 source FIFO head (first-word-fall-through).
- src0_empty  in  1  requester 0 source FIFO empty.
- src0_rd_en  out  1  pop requester 0 source FIFO.
- src1_data  in  8  requester 1 source FIFO head.
- src1_empty  in  1  requester 1 source FIFO empty.
- src1_rd_en  out  1  pop requester 1 source FIFO.
- dst0_full  in  1  requester 0 destination FIFO full.
- dst0_wr_en  out  1  push requester 0 destination FIFO.
- dst1_full  in  1  requester 1 destination FIFO full.
- dst1_wr_en  out  1  push requester 1 destination FIFO.
- dst_data  out  8  shared write data to both destination FIFOs (= filt_dout).
- filt_din  out  8  filter input.
- filt_dout  in  8  filter output.
- filt_clk_en  out  1  filter clock enable.
- filt_reset  out  1  filter reset.
- grant  out  1  requester currently owning the filter.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when a frame's last output is written.

Behaviour:
- State machine: IDLE, CLEAR, RUN, FLUSH. State, grant, priority pointer, step_cnt (18b) and frame_done are registered. Strobes are combinational from registered state and inputs.
- Reset: state=IDLE, grant=0, priority=0, step_cnt=0, frame_done=0. All rd_en, wr_en and filt_clk_en are 0. filt_reset=1 while global_reset is high. Reset mid-frame abandons the frame; no partial pixels are written afterwards.
- IDLE: a requester is eligible when its srcN_empty=0.
  - If both are eligible, grant = priority. Otherwise grant the single eligible one.
  - On any grant: latch grant, go to CLEAR. If none is eligible, stay in IDLE.
- CLEAR: exactly one cycle. filt_reset=1, filt_clk_en=0, step_cnt<=0, then go to RUN.
- step (combinational):
  - RUN: step = !src_empty[grant] & !dst_full[grant].
  - FLUSH: step = !dst_full[grant].
  - Otherwise step = 0.
  - Gating on dst_full during RUN is mandatory so that no output is dropped.
- Outputs while stepping:
  - filt_clk_en = step.
  - filt_din = src_data[grant] in RUN, 8'd0 in FLUSH (and 0 in other states).
  - srcN_rd_en = step & (state==RUN) & (grant==N).
  - dstN_wr_en = step & (step_cnt >= LAT) & (grant==N).
  - dst_data = filt_dout. The non-granted requester's strobes are always 0.
- step_cnt increments on every step.
  - RUN -> FLUSH on the step where step_cnt == PIX-1.
  - FLUSH -> IDLE on the step where step_cnt == PIX+LAT-1. That step is the PIX-th write.
  - frame_done is registered high for the following cycle, and priority <= ~grant.
- Write accounting: exactly PIX writes and exactly PIX reads per frame. Output order equals input order.
- Stalls: while step=0 the filter is frozen (clk_en=0), counters hold and no strobes fire. Stalls of any length and at any position are legal.
- Simultaneous events:
  - An eligible requester that becomes non-empty during another's frame waits until IDLE.
  - IDLE always lasts at least 1 cycle between frames.
  - The non-granted requester's FIFO flags are ignored entirely.

Test Plan (IMG_W=4, IMG_H=2, LAT=3, PIX=8, filter model = 3-stage enabled delay line):
- Reset, src0 holds pixels 1..8, dst never full -> CLEAR 1 cycle, 8 src0_rd_en pulses, dst0_wr_en pulses carrying 1..8, 11 steps total, frame_done one cycle after the last write, busy drops, dst1_wr_en never asserted.
- Both sources non-empty in IDLE after reset -> grant=0 first. On completion grant=1 for the next frame, then grant=0 again. Check round-robin over 3 frames.
- dst0_full held high for 5 cycles mid-RUN, then held again during FLUSH -> filt_clk_en, rd_en and wr_en all 0 during stalls. Still exactly 8 writes with values 1..8 in order.
- src0_empty toggles every other cycle in RUN -> reads occur only when not empty. Output sequence unchanged. FLUSH proceeds independently of src0_empty.
- global_reset asserted after 5 steps, src1 then non-empty -> IDLE and filt_reset high during reset. No further dst0 writes. Next frame is granted to src1 with a fresh CLEAR and 8 correct outputs.
- Only src1 non-empty while priority=0 -> grant=1 immediately. No dead cycles beyond the single IDLE and CLEAR cycles.

Source files
------------

// File: rtl/gaussian_frame_arbiter.sv
// gaussian_frame_arbiter: time-shares one Gaussian filter between two octave
// streams. The arbiter owns the filter for a whole frame: it clears the
// pipeline, streams PIX pixels in, then pads with zeros for LAT steps so that
// the last real pixel reaches the destination FIFO.
//
// Handshake: a source word is consumed on a cycle where src*_rd_en is high
// (the FIFO head is first-word-fall-through, so data is valid whenever
// src*_empty is low), and a destination word is accepted on a cycle where
// dst*_wr_en is high. Neither strobe is ever raised while the corresponding
// empty/full flag is high, and the filter only advances on those same cycles.
module gaussian_frame_arbiter #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int LAT   = 323
) (
    input  logic       clk,
    input  logic       global_reset,
    input  logic [7:0] src0_data,
    input  logic       src0_empty,
    output logic       src0_rd_en,
    input  logic [7:0] src1_data,
    input  logic       src1_empty,
    output logic       src1_rd_en,
    input  logic       dst0_full,
    output logic       dst0_wr_en,
    input  logic       dst1_full,
    output logic       dst1_wr_en,
    output logic [7:0] dst_data,
    output logic [7:0] filt_din,
    input  logic [7:0] filt_dout,
    output logic       filt_clk_en,
    output logic       filt_reset,
    output logic       grant,
    output logic       busy,
    output logic       frame_done
);

    localparam int PIX = IMG_W * IMG_H;
    localparam logic [17:0] LAST_RD   = 18'(PIX - 1);
    localparam logic [17:0] LAST_STEP = 18'(PIX + LAT - 1);
    localparam logic [17:0] LAT_CNT   = 18'(LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        prio_q, prio_d;
    logic        done_q, done_d;
    logic [17:0] cnt_q, cnt_d;

    logic        sel_empty;
    logic        sel_full;
    logic [7:0]  sel_data;
    logic        step;
    logic        wr;

    // Route the granted requester's flags and data; the other side is ignored.
    always_comb begin
        sel_empty = grant_q ? src1_empty : src0_empty;
        sel_full  = grant_q ? dst1_full  : dst0_full;
        sel_data  = grant_q ? src1_data  : src0_data;
    end

    // A step advances the filter by one enabled clock; reset freezes everything.
    always_comb begin
        step = 1'b0;
        if (!global_reset) begin
            case (state_q)
                RUN:     step = !sel_empty && !sel_full;
                FLUSH:   step = !sel_full;
                default: step = 1'b0;
            endcase
        end
    end

    // Outputs before LAT steps are pipeline fill and are not written.
    assign wr          = step && (cnt_q >= LAT_CNT);
    assign filt_clk_en = step;
    assign filt_din    = (state_q == RUN) ? sel_data : 8'd0;
    assign src0_rd_en  = step && (state_q == RUN) && !grant_q;
    assign src1_rd_en  = step && (state_q == RUN) && grant_q;
    assign dst0_wr_en  = wr && !grant_q;
    assign dst1_wr_en  = wr && grant_q;
    assign dst_data    = filt_dout;
    assign filt_reset  = global_reset || (state_q == CLEAR);
    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign frame_done  = done_q;

    // Next-state: arbitration in IDLE, step counting through RUN and FLUSH.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!src0_empty && !src1_empty) begin
                    grant_d = prio_q;
                    state_d = CLEAR;
                end else if (!src0_empty) begin
                    grant_d = 1'b0;
                    state_d = CLEAR;
                end else if (!src1_empty) begin
                    grant_d = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = 18'd0;
                state_d = RUN;
            end
            RUN: begin
                if (step) begin
                    cnt_d = cnt_q + 18'd1;
                    if (cnt_q == LAST_RD) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (step) begin
                    cnt_d = cnt_q + 18'd1;
                    if (cnt_q == LAST_STEP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        prio_d  = !grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; a reset abandons any frame.
    always_ff @(posedge clk) begin
        if (global_reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= 18'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_gaussian_frame_arbiter.sv
// Directed bench for gaussian_frame_arbiter with a 4x2 frame and a 3-stage
// enabled delay line standing in for the filter.
module tb_gaussian_frame_arbiter;

    logic       clk = 1'b0;
    logic       global_reset;
    logic [7:0] src0_data, src1_data;
    logic       src0_empty, src1_empty;
    logic       src0_rd_en, src1_rd_en;
    logic       dst0_full, dst1_full;
    logic       dst0_wr_en, dst1_wr_en;
    logic [7:0] dst_data, filt_din, filt_dout;
    logic       filt_clk_en, filt_reset, grant, busy, frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Clock and reset block
    always #5 clk = ~clk;

    gaussian_frame_arbiter #(.IMG_W(4), .IMG_H(2), .LAT(3)) dut (
        .clk(clk), .global_reset(global_reset),
        .src0_data(src0_data), .src0_empty(src0_empty), .src0_rd_en(src0_rd_en),
        .src1_data(src1_data), .src1_empty(src1_empty), .src1_rd_en(src1_rd_en),
        .dst0_full(dst0_full), .dst0_wr_en(dst0_wr_en),
        .dst1_full(dst1_full), .dst1_wr_en(dst1_wr_en),
        .dst_data(dst_data), .filt_din(filt_din), .filt_dout(filt_dout),
        .filt_clk_en(filt_clk_en), .filt_reset(filt_reset),
        .grant(grant), .busy(busy), .frame_done(frame_done)
    );

    // Filter model: 3-stage delay line advancing only when enabled
    logic [7:0] fs0 = 8'd0, fs1 = 8'd0, fs2 = 8'd0;
    always @(posedge clk) begin
        if (filt_reset) begin
            fs0 <= 8'd0; fs1 <= 8'd0; fs2 <= 8'd0;
        end else if (filt_clk_en) begin
            fs0 <= filt_din; fs1 <= fs0; fs2 <= fs1;
        end
    end
    assign filt_dout = fs2;

    // Source FIFO models (first-word-fall-through), with a forced-empty hold
    logic [7:0] mem0 [0:63];
    logic [7:0] mem1 [0:63];
    int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
    logic hold0, hold1;
    assign src0_empty = hold0 || (rd0 >= wr0);
    assign src1_empty = hold1 || (rd1 >= wr1);
    assign src0_data  = mem0[rd0[5:0]];
    assign src1_data  = mem1[rd1[5:0]];
    always @(posedge clk) begin
        if (src0_rd_en) rd0 <= rd0 + 1;
        if (src1_rd_en) rd1 <= rd1 + 1;
    end

    int step_n = 0;
    always @(posedge clk) if (filt_clk_en) step_n <= step_n + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard: expected destination words in order
    logic [7:0] exp0_q[$];
    logic [7:0] exp1_q[$];
    always @(posedge clk) begin
        if (dst0_wr_en) begin
            if (exp0_q.size() == 0) check("dst0_extra_write", {31'd0, dst0_wr_en}, 32'd0);
            else check("dst0_data", {24'd0, dst_data}, {24'd0, exp0_q.pop_front()});
        end
        if (dst1_wr_en) begin
            if (exp1_q.size() == 0) check("dst1_extra_write", {31'd0, dst1_wr_en}, 32'd0);
            else check("dst1_data", {24'd0, dst_data}, {24'd0, exp1_q.pop_front()});
        end
    end

    // Driver tasks
    task automatic load0(input logic [7:0] base, input bit expect_out);
        for (int i = 0; i < 8; i++) begin
            mem0[wr0[5:0]] = base + 8'(i);
            if (expect_out) exp0_q.push_back(base + 8'(i));
            wr0++;
        end
    endtask

    task automatic load1(input logic [7:0] base, input bit expect_out);
        for (int i = 0; i < 8; i++) begin
            mem1[wr1[5:0]] = base + 8'(i);
            if (expect_out) exp1_q.push_back(base + 8'(i));
            wr1++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Bounded wait for frame_done, counting negedges from the call
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (!frame_done && cyc < 200);
        check("frame_done_seen", {31'd0, frame_done}, 32'd1);
    endtask

    int cyc, s0, r0;

    initial begin
        global_reset = 1'b1;
        dst0_full = 1'b0; dst1_full = 1'b0;
        hold0 = 1'b0; hold1 = 1'b0;

        // Test 1: single frame from src0
        load0(8'd1, 1'b1);
        repeat (3) tick();
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {31'd0, grant}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_filt_reset", {31'd0, filt_reset}, 32'd1);
        check("rst_clk_en", {31'd0, filt_clk_en}, 32'd0);
        check("rst_rd_en", {31'd0, src0_rd_en}, 32'd0);
        tick();
        global_reset = 1'b0;
        s0 = step_n;
        tick(); #1;
        check("clear_busy", {31'd0, busy}, 32'd1);
        check("clear_filt_reset", {31'd0, filt_reset}, 32'd1);
        check("clear_clk_en", {31'd0, filt_clk_en}, 32'd0);
        tick(); #1;
        check("run_filt_reset", {31'd0, filt_reset}, 32'd0);
        check("run_rd_en", {31'd0, src0_rd_en}, 32'd1);
        check("run_din", {24'd0, filt_din}, 32'd1);
        wait_done(cyc);
        check("t1_cycles", cyc, 32'd11);
        check("t1_busy_at_done", {31'd0, busy}, 32'd0);
        check("t1_grant", {31'd0, grant}, 32'd0);
        check("t1_steps", step_n - s0, 32'd11);
        check("t1_reads", rd0, 32'd8);
        check("t1_exp_left", exp0_q.size(), 32'd0);
        tick(); #1;
        check("t1_done_pulse", {31'd0, frame_done}, 32'd0);
        check("t1_idle", {31'd0, busy}, 32'd0);

        // Test 2: round-robin over three frames
        global_reset = 1'b1;
        load0(8'h21, 1'b1);
        load0(8'h41, 1'b1);
        load1(8'h31, 1'b1);
        repeat (2) tick();
        global_reset = 1'b0;
        wait_done(cyc);
        check("t2_f1_cycles", cyc, 32'd13);
        check("t2_f1_grant", {31'd0, grant}, 32'd0);
        wait_done(cyc);
        check("t2_f2_cycles", cyc, 32'd13);
        check("t2_f2_grant", {31'd0, grant}, 32'd1);
        wait_done(cyc);
        check("t2_f3_cycles", cyc, 32'd13);
        check("t2_f3_grant", {31'd0, grant}, 32'd0);
        check("t2_exp0_left", exp0_q.size(), 32'd0);
        check("t2_exp1_left", exp1_q.size(), 32'd0);

        // Test 3: destination stalls in RUN and in FLUSH
        tick();
        global_reset = 1'b1;
        load0(8'd1, 1'b1);
        repeat (2) tick();
        global_reset = 1'b0;
        r0 = rd0;
        s0 = step_n;
        repeat (3) tick();
        dst0_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_run_stall_clk_en", {31'd0, filt_clk_en}, 32'd0);
            check("t3_run_stall_rd_en", {31'd0, src0_rd_en}, 32'd0);
            check("t3_run_stall_wr_en", {31'd0, dst0_wr_en}, 32'd0);
            tick();
        end
        dst0_full = 1'b0;
        cyc = 0;
        while ((rd0 - r0) < 8 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("t3_reads", rd0 - r0, 32'd8);
        tick();
        dst0_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_flush_stall_clk_en", {31'd0, filt_clk_en}, 32'd0);
            check("t3_flush_stall_wr_en", {31'd0, dst0_wr_en}, 32'd0);
            tick();
        end
        dst0_full = 1'b0;
        wait_done(cyc);
        check("t3_steps", step_n - s0, 32'd11);
        check("t3_exp_left", exp0_q.size(), 32'd0);

        // Test 4: src0_empty toggling during the frame
        load0(8'h51, 1'b1);
        r0 = rd0;
        s0 = step_n;
        cyc = 0;
        do begin
            tick();
            hold0 = ~hold0;
            #1;
            cyc++;
            if (busy && (rd0 - r0) < 8 && hold0) begin
                check("t4_empty_clk_en", {31'd0, filt_clk_en}, 32'd0);
                check("t4_empty_rd_en", {31'd0, src0_rd_en}, 32'd0);
            end
            if (busy && (rd0 - r0) == 8)
                check("t4_flush_clk_en", {31'd0, filt_clk_en}, 32'd1);
        end while (!frame_done && cyc < 200);
        check("t4_done", {31'd0, frame_done}, 32'd1);
        hold0 = 1'b0;
        check("t4_reads", rd0 - r0, 32'd8);
        check("t4_steps", step_n - s0, 32'd11);
        check("t4_exp_left", exp0_q.size(), 32'd0);

        // Test 5: reset in the middle of a src0 frame, then a src1 frame
        tick();
        global_reset = 1'b1;
        tick();
        load0(8'h61, 1'b0);
        exp0_q.push_back(8'h61);
        exp0_q.push_back(8'h62);
        r0 = rd0;
        global_reset = 1'b0;
        repeat (7) tick();
        global_reset = 1'b1;
        hold0 = 1'b1;
        load1(8'h71, 1'b1);
        #1;
        check("t5_rst_filt_reset", {31'd0, filt_reset}, 32'd1);
        check("t5_rst_clk_en", {31'd0, filt_clk_en}, 32'd0);
        check("t5_rst_rd_en", {31'd0, src0_rd_en}, 32'd0);
        check("t5_rst_wr_en", {31'd0, dst0_wr_en}, 32'd0);
        check("t5_reads_before_rst", rd0 - r0, 32'd5);
        tick(); #1;
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_filt_reset2", {31'd0, filt_reset}, 32'd1);
        tick();
        global_reset = 1'b0;
        wait_done(cyc);
        check("t5_cycles", cyc, 32'd13);
        check("t5_grant", {31'd0, grant}, 32'd1);
        check("t5_exp0_left", exp0_q.size(), 32'd0);
        check("t5_exp1_left", exp1_q.size(), 32'd0);

        // Test 6: only src1 eligible while priority points at requester 0
        tick();
        load1(8'h81, 1'b1);
        wait_done(cyc);
        check("t6_cycles", cyc, 32'd13);
        check("t6_grant", {31'd0, grant}, 32'd1);
        check("t6_exp1_left", exp1_q.size(), 32'd0);
        repeat (3) tick();
        #1;
        check("t6_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
